// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor: computes a - b - bin, LSB first, one bit
//   per clock, with a registered borrow between bits. Operands are taken on a
//   start/done handshake so back-to-back operations are possible.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : operation request, accepted when not busy
//   a, b   : minuend / subtrahend, sampled with start
//   bin    : borrow-in, sampled with start
//   busy   : high while bits are being processed (SHIFT state)
//   done   : one-cycle pulse, diff/bout hold the new result
//   diff   : registered difference, modulo 2^WIDTH
//   bout   : registered final borrow-out (1 means a < b + bin, unsigned)
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       fs;      // {borrow-out, difference bit} of the current bit
  logic [WIDTH-1:0] res_sh;  // result register after this cycle's shift
  logic             load;

  // One-bit full subtractor: returns {borrow_out, diff}.
  function automatic logic [1:0] full_sub(input logic x, input logic y,
                                          input logic bi);
    logic d;
    logic bo;
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
    return {bo, d};
  endfunction

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    load    = 1'b0;

    fs     = full_sub(a_sr_q[0], b_sr_q[0], brw_q);
    // New bit enters at the MSB so after WIDTH shifts bit 0 is the LSB.
    res_sh = res_q >> 1;
    res_sh[WIDTH-1] = fs[0];

    case (state_q)
      IDLE: begin
        if (start) load = 1'b1;
      end
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        res_d  = res_sh;
        brw_d  = fs[1];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          diff_d  = res_sh;
          bout_d  = fs[1];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        // Accepting here gives back-to-back operation with start held high.
        if (start) load = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      a_sr_d  = a;
      b_sr_d  = b;
      brw_d   = bin;
      res_d   = '0;
      cnt_d   = '0;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing a - b - bin, LSB first, one bit per clock.
- Uses full-subtractor logic with a registered borrow.
- The sequential inverse-operation counterpart of the combinational full adder.
- Sits behind a start/done handshake so a controller or bench can issue back-to-back operations.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32)

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
start  input   1      request; operands sampled on the rising edge where start=1 and the block is not busy
a      input   WIDTH  minuend, sampled with start
b      input   WIDTH  subtrahend, sampled with start
bin    input   1      borrow-in, sampled with start
busy   output  1      high while bits are being processed
done   output  1      one-cycle pulse: diff/bout valid
diff   output  WIDTH  registered difference
bout   output  1      registered final borrow-out (1 means a < b + bin as unsigned)

Behaviour:
- One clock. Reset is asynchronous and active-low, on rst_n.
- Reset state, taken immediately on rst_n=0:
  - state IDLE.
  - busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow and counter all 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: capture a, b and bin into a_sr, b_sr and brw. Clear the counter and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, on each edge:
  - d = a_sr[0] ^ b_sr[0] ^ brw.
  - brw <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw).
  - d shifts into the MSB of the result register, which shifts right.
  - a_sr and b_sr shift right; counter increments.
  - On the edge where the counter equals WIDTH-1: diff <= completed result (including this bit), bout <= new brw, go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - If start=1 on this edge, capture new operands and go to SHIFT (back-to-back). Otherwise go to IDLE.
- busy=1 exactly while in SHIFT.
- start is ignored while busy=1. Operand changes during SHIFT have no effect.
- Latency: the start edge is E0. SHIFT edges are E1..E_WIDTH. done is high between E_WIDTH and E_WIDTH+1. busy is high between E0 and E_WIDTH, i.e. WIDTH cycles.
- Throughput with start held high: one result every WIDTH+1 cycles.
- diff and bout hold their last values until the next completion. They do not change during SHIFT.
- Arithmetic is modulo 2^WIDTH. diff = (a - b - bin) mod 2^WIDTH. bout = 1 iff a < b + bin, evaluated unsigned with WIDTH+1-bit precision.
- WIDTH=1: exactly one SHIFT cycle, then DONE; behaves as a registered full subtractor.
- Reset asserted mid-operation: the operation is abandoned and all outputs return to reset values. No done is produced.
- Reset released with start=1 on the first edge: start is accepted normally.

Test Plan:
- WIDTH=8, a=0x5A, b=0x23, bin=0, one-cycle start -> busy high 8 cycles; done pulse 8 edges after start; diff=0x37, bout=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x00, b=0xFF, bin=1 -> diff=0x00, bout=1.
- a=0x80, b=0x80, bin=0, start held high continuously for 3 operations -> done pulses every 9 cycles; each diff=0x00, bout=0; no cycle with busy=0 and done=0 between operations.
- Start pulsed with a=0x10, b=0x01. Then during busy, start=1 with a=0xFF, b=0x00 -> second request ignored; single done with diff=0x0F, bout=0.
- Reset: begin a=0x5A, b=0x23; drop rst_n after 4 SHIFT cycles, asynchronously -> busy, done, diff and bout go 0 immediately; no done follows. A new start after release yields the correct result.
- WIDTH=1 instance, all 8 (a,b,bin) combinations in order 000..111 -> diff/bout = 0/0, 1/1, 1/1, 0/1, 1/0, 0/0, 0/0, 1/1. Each done arrives 1 edge after its start.
